unified_memory_arbiter: RTL

UNIFIED_MEMORY_ARBITER -- requirements
Module: unified_memory_arbiter

---
 rtl/unified_memory_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: arbitrates the fetch stage and the MEM stage onto a
// single-port memory. One transaction is outstanding at a time. The request
// fields are registered when the grant is made and are held until ramAck.
// The owner's valid strobe follows ramAck by one cycle.
// Data requests win by default. Define MEM_ARB_STARVE_GUARD_EN to add a
// counter that forces a fetch grant after STARVE_LIMIT consecutive data grants
// made while a fetch was waiting.
module unified_memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifReq,
  input  logic [ADDR_WIDTH-1:0] ifAddr,
  output logic [DATA_WIDTH-1:0] ifRdata,
  output logic                  ifValid,
  input  logic                  memReq,
  input  logic                  memWe,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memWdata,
  output logic [DATA_WIDTH-1:0] memRdata,
  output logic                  memValid,
  output logic                  ramReq,
  output logic                  ramWe,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0] ramWdata,
  input  logic [DATA_WIDTH-1:0] ramRdata,
  input  logic                  ramAck
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    ram_req_q;
  logic                    ram_we_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [DATA_WIDTH-1:0]   ram_wdata_q;
  logic                    if_valid_q;
  logic                    mem_valid_q;
  logic [DATA_WIDTH-1:0]   if_rdata_q;
  logic [DATA_WIDTH-1:0]   mem_rdata_q;

  logic starved;
  logic grant_if;
  logic grant_mem;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;

  assign starved = (starve_q == CW'(STARVE_LIMIT));

  // Starvation count: bumps on a data grant that passes over a waiting fetch,
  // clears on any fetch grant or on an arbitration with no fetch waiting.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && (memReq || ifReq)) begin
      if (grant_if) begin
        starve_d = '0;
      end else if (ifReq) begin
        starve_d = starved ? starve_q : starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic starve_unused;

  assign starved       = 1'b0;
  assign starve_unused = (STARVE_LIMIT != 0);
`endif

  // Arbitration decision. It takes effect only in IDLE.
  always_comb begin
    grant_if  = ifReq && (!memReq || starved);
    grant_mem = memReq && !grant_if;
  end

  // Arbiter FSM. All memory-side and requester-side outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= memWe;
            ram_addr_q  <= memAddr;
            ram_wdata_q <= memWdata;
            state_q     <= GRANT_MEM;
          end else if (grant_if) begin
            ram_req_q   <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= ifAddr;
            ram_wdata_q <= '0;
            state_q     <= GRANT_IF;
          end
        end
        GRANT_IF: begin
          if (ramAck) begin
            ram_req_q  <= 1'b0;
            if_valid_q <= 1'b1;
            if_rdata_q <= ramRdata;
            state_q    <= IDLE;
          end
        end
        GRANT_MEM: begin
          if (ramAck) begin
            ram_req_q   <= 1'b0;
            mem_valid_q <= 1'b1;
            mem_rdata_q <= ram_we_q ? '0 : ramRdata;
            state_q     <= IDLE;
          end
        end
        default: begin
          ram_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ramReq   = ram_req_q;
  assign ramWe    = ram_we_q;
  assign ramAddr  = ram_addr_q;
  assign ramWdata = ram_wdata_q;
  assign ifValid  = if_valid_q;
  assign ifRdata  = if_rdata_q;
  assign memValid = mem_valid_q;
  assign memRdata = mem_rdata_q;

endmodule
